pixel_window: RTL and testbench

Parametrised sliding-window pixel buffer for the VGA pixel path. It accepts a stream of pixels qualified by valid and line markers, and emits one TAPS-wide horizontal window per pixel, centred on that pixel. Windows never straddle two lines; missing neighbours at line edges are replicated or zeroed. It sits between the pixel source and neighbourhood filters such as edge detection and smoothing, and generalises the fixed three-pixel prev/current/next buffer.

---
 rtl/pixel_window_if.sv | 30 +++
 rtl/pixel_window.sv | 155 +++++++++++++++
 tb/tb_pixel_window.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_window_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_window_if : pixel stream in, TAPS-wide window stream out           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface pixel_window_if #(
    parameter int PIX_W = 8,
    parameter int TAPS  = 3
);
    logic [PIX_W-1:0]      pix_in;
    logic                  pix_valid;
    logic                  line_start;
    logic                  line_end;
    logic                  pix_ready;
    logic [PIX_W*TAPS-1:0] win_data;
    logic                  win_valid;
    logic                  win_first;
    logic                  win_last;

    modport master (
        output pix_in, pix_valid, line_start, line_end,
        input  pix_ready, win_data, win_valid, win_first, win_last
    );

    modport slave (
        input  pix_in, pix_valid, line_start, line_end,
        output pix_ready, win_data, win_valid, win_first, win_last
    );
endinterface
`default_nettype wire

// File: rtl/pixel_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_window : sliding horizontal window centred on each line pixel.     |
// | PIXEL_WINDOW_EDGE_REPLICATE_EN: edge taps copy p0/pN-1 instead of 0.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pixel_window #(
    parameter int PIX_W = 8,
    parameter int TAPS  = 3
) (
    input  logic          VGA_CLK,
    input  logic          RST_N,
    pixel_window_if.slave pix
);
    localparam int HALF  = (TAPS - 1) / 2;
    localparam int CNT_W = 16;
    localparam int FL_W  = 4;
    localparam int IDX_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [FL_W-1:0]               flush_q;
    logic [TAPS-2:0][PIX_W-1:0]    hist_q;
    logic [PIX_W-1:0]              pad_q;
    logic                          first_q;
    logic                          pix_ready_q;
    logic [TAPS-1:0][PIX_W-1:0]    win_data_q;
    logic                          win_valid_q;
    logic                          win_first_q;
    logic                          win_last_q;

    logic                          accept_d;
    logic                          open_d;
    logic                          emit_d;
    logic                          first_d;
    logic [CNT_W-1:0]              cnt_d;
    logic [FL_W-1:0]               fcnt_d;
    logic [FL_W-1:0]               extra_d;
    logic [PIX_W-1:0]              edge_fill_d;
    logic [TAPS-1:0][PIX_W-1:0]    win_new_d;
    logic [TAPS-1:0][PIX_W-1:0]    win_flush_d;
    logic [TAPS-2:0][PIX_W-1:0]    hist_d;
    int                            src_d;

    // Edge fill is only ever sampled on the p0 or pN-1 accept, so pix_in is the edge pixel.
`ifdef PIXEL_WINDOW_EDGE_REPLICATE_EN
    assign edge_fill_d = pix.pix_in;
`else
    assign edge_fill_d = '0;
`endif

    always_comb begin
        accept_d = pix.pix_valid & pix_ready_q;
        open_d   = pix.line_start | (state_q == ST_RUN);
        first_d  = pix.line_start | first_q;
        cnt_d    = pix.line_start ? CNT_W'(1)
                 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        emit_d   = (cnt_d > HALF_CNT);
        fcnt_d   = (cnt_d < HALF_CNT) ? cnt_d[FL_W-1:0] : FL_W'(HALF);
        extra_d  = (pix.line_end && (cnt_d < HALF_CNT)) ? FL_W'(HALF_CNT - cnt_d) : '0;

        if (pix.line_start) begin
            win_new_d         = {TAPS{edge_fill_d}};
            win_new_d[TAPS-1] = pix.pix_in;
        end else begin
            win_new_d = {pix.pix_in, hist_q};
        end
        win_flush_d = {pad_q, hist_q};

        // Lines shorter than HALF pre-shift the pad so the first flush window is centred on p0.
        src_d = 0;
        for (int k = 0; k < TAPS - 1; k++) begin
            src_d = k + 1 + int'(extra_d);
            if (src_d < TAPS) begin
                hist_d[k] = win_new_d[src_d[IDX_W-1:0]];
            end else begin
                hist_d[k] = edge_fill_d;
            end
        end
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flush_q     <= '0;
            hist_q      <= '0;
            pad_q       <= '0;
            first_q     <= 1'b0;
            pix_ready_q <= 1'b1;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (accept_d && open_d) begin
                        cnt_q  <= cnt_d;
                        hist_q <= hist_d;
                        if (emit_d) begin
                            win_data_q  <= win_new_d;
                            win_valid_q <= 1'b1;
                            win_first_q <= first_d;
                            first_q     <= 1'b0;
                        end else begin
                            first_q     <= first_d;
                        end
                        if (pix.line_end) begin
                            state_q     <= ST_FLUSH;
                            flush_q     <= fcnt_d;
                            pad_q       <= edge_fill_d;
                            pix_ready_q <= 1'b0;
                        end else begin
                            state_q     <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    hist_q      <= win_flush_d[TAPS-1:1];
                    win_data_q  <= win_flush_d;
                    win_valid_q <= 1'b1;
                    win_first_q <= first_q;
                    win_last_q  <= (flush_q == FL_W'(1));
                    first_q     <= 1'b0;
                    flush_q     <= flush_q - FL_W'(1);
                    if (flush_q == FL_W'(1)) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        pix_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix.pix_ready = pix_ready_q;
    assign pix.win_data  = win_data_q;
    assign pix.win_valid = win_valid_q;
    assign pix.win_first = win_first_q;
    assign pix.win_last  = win_last_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_window : table vectors plus scoreboard for TAPS=3 and TAPS=5.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pixel_window;
`ifdef PIXEL_WINDOW_EDGE_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pixel_window_if #(.PIX_W(8), .TAPS(3)) if3 ();
    pixel_window_if #(.PIX_W(8), .TAPS(5)) if5 ();

    pixel_window #(.PIX_W(8), .TAPS(3)) u_dut3 (.VGA_CLK(clk), .RST_N(rst_n), .pix(if3.slave));
    pixel_window #(.PIX_W(8), .TAPS(5)) u_dut5 (.VGA_CLK(clk), .RST_N(rst_n), .pix(if5.slave));

    typedef struct packed {
        logic [39:0] d;
        logic        f;
        logic        l;
    } win_t;

    typedef struct {
        int          sel;
        int          n;
        logic [7:0]  pix [4];
        logic [39:0] rep [4];
        logic [39:0] zer [4];
    } vec_t;

    win_t q3[$];
    win_t q5[$];
    vec_t tbl [6];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [39:0] pk3(input logic [7:0] a, b, c);
        return {16'd0, c, b, a};
    endfunction

    function automatic logic [39:0] pk5(input logic [7:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input win_t w);
        if (sel == 0) q3.push_back(w);
        else          q5.push_back(w);
    endtask

    // Independent window model: clamp or zero each out-of-line index.
    task automatic push_line(input int sel, input logic [7:0] p [16], input int n,
                             input int k, input bit complete);
        int taps;
        int half;
        taps = (sel == 0) ? 3 : 5;
        half = (taps - 1) / 2;
        for (int c = 0; c < k; c++) begin
            win_t w;
            w.d = '0;
            for (int t = 0; t < taps; t++) begin
                int idx;
                logic [7:0] v;
                idx = c - half + t;
                if (idx < 0)       v = REP ? p[0] : 8'd0;
                else if (idx >= n) v = REP ? p[n-1] : 8'd0;
                else               v = p[idx];
                w.d[t*8 +: 8] = v;
            end
            w.f = (c == 0);
            w.l = complete && (c == n - 1);
            push(sel, w);
        end
    endtask

    task automatic mon(input int sel, input logic [39:0] d, input logic f, input logic l);
        win_t e;
        if ((sel == 0 && q3.size() == 0) || (sel == 1 && q5.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL unexpected_window sel=%0d actual=%0h required=none", sel, d);
        end else begin
            e = (sel == 0) ? q3.pop_front() : q5.pop_front();
            chk(sel == 0 ? "window_t3" : "window_t5", {22'd0, d, f, l}, {22'd0, e.d, e.f, e.l});
        end
    endtask

    always @(negedge clk) begin
        if (if3.win_valid) mon(0, {16'd0, if3.win_data}, if3.win_first, if3.win_last);
        if (if5.win_valid) mon(1, if5.win_data, if5.win_first, if5.win_last);
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] p, input logic ls, input logic le);
        if (sel == 0) begin
            if3.pix_valid = v; if3.pix_in = p; if3.line_start = ls; if3.line_end = le;
        end else begin
            if5.pix_valid = v; if5.pix_in = p; if5.line_start = ls; if5.line_end = le;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if3.pix_ready : if5.pix_ready;
    endfunction

    task automatic idle(input int sel);
        drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    // Holds the pixel until accepted; waits = cycles it sat with pix_ready low.
    task automatic send(input int sel, input logic [7:0] p, input logic ls, input logic le,
                        output int waits);
        logic r;
        drive(sel, 1'b1, p, ls, le);
        waits = 0;
        forever begin
            @(negedge clk);
            r = rdy(sel);
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits >= 40) begin
                checks++;
                fails++;
                $display("FAIL send_timeout sel=%0d actual=not_ready required=ready", sel);
                break;
            end
        end
    endtask

    task automatic bubble(input int sel, output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rdy(sel)) break;
            cnt++;
            if (cnt > 40) break;
        end
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_valid3"}, if3.win_valid, 0);
        chk({tag, "_first3"}, if3.win_first, 0);
        chk({tag, "_last3"},  if3.win_last,  0);
        chk({tag, "_data3"},  if3.win_data,  0);
        chk({tag, "_ready3"}, if3.pix_ready, 1);
        chk({tag, "_valid5"}, if5.win_valid, 0);
        chk({tag, "_data5"},  if5.win_data,  0);
        chk({tag, "_ready5"}, if5.pix_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b;
        logic [7:0] lp [16];

        tbl[0].sel = 0; tbl[0].n = 4; tbl[0].pix = '{8'd10, 8'd20, 8'd30, 8'd40};
        tbl[0].rep = '{pk3(10,10,20), pk3(10,20,30), pk3(20,30,40), pk3(30,40,40)};
        tbl[0].zer = '{pk3(0,10,20),  pk3(10,20,30), pk3(20,30,40), pk3(30,40,0)};
        tbl[1].sel = 0; tbl[1].n = 1; tbl[1].pix = '{8'd55, 8'd0, 8'd0, 8'd0};
        tbl[1].rep = '{pk3(55,55,55), 40'd0, 40'd0, 40'd0};
        tbl[1].zer = '{pk3(0,55,0),   40'd0, 40'd0, 40'd0};
        tbl[2].sel = 1; tbl[2].n = 2; tbl[2].pix = '{8'd1, 8'd2, 8'd0, 8'd0};
        tbl[2].rep = '{pk5(1,1,1,2,2), pk5(1,1,2,2,2), 40'd0, 40'd0};
        tbl[2].zer = '{pk5(0,0,1,2,0), pk5(0,1,2,0,0), 40'd0, 40'd0};
        tbl[3].sel = 0; tbl[3].n = 2; tbl[3].pix = '{8'd100, 8'd200, 8'd0, 8'd0};
        tbl[3].rep = '{pk3(100,100,200), pk3(100,200,200), 40'd0, 40'd0};
        tbl[3].zer = '{pk3(0,100,200),   pk3(100,200,0),   40'd0, 40'd0};
        tbl[4].sel = 1; tbl[4].n = 4; tbl[4].pix = '{8'd5, 8'd6, 8'd7, 8'd8};
        tbl[4].rep = '{pk5(5,5,5,6,7), pk5(5,5,6,7,8), pk5(5,6,7,8,8), pk5(6,7,8,8,8)};
        tbl[4].zer = '{pk5(0,0,5,6,7), pk5(0,5,6,7,8), pk5(5,6,7,8,0), pk5(6,7,8,0,0)};
        tbl[5].sel = 1; tbl[5].n = 1; tbl[5].pix = '{8'd9, 8'd0, 8'd0, 8'd0};
        tbl[5].rep = '{pk5(9,9,9,9,9), 40'd0, 40'd0, 40'd0};
        tbl[5].zer = '{pk5(0,0,9,0,0), 40'd0, 40'd0, 40'd0};

        idle(0);
        idle(1);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            int half;
            half = (tbl[i].sel == 0) ? 1 : 2;
            for (int j = 0; j < tbl[i].n; j++) begin
                win_t e;
                e.d = REP ? tbl[i].rep[j] : tbl[i].zer[j];
                e.f = (j == 0);
                e.l = (j == tbl[i].n - 1);
                push(tbl[i].sel, e);
            end
            for (int j = 0; j < tbl[i].n; j++) begin
                send(tbl[i].sel, tbl[i].pix[j], j == 0, j == tbl[i].n - 1, w);
                if (j > 0) chk("back_to_back", w, 0);
            end
            idle(tbl[i].sel);
            bubble(tbl[i].sel, b);
            chk("ready_bubble", b, (tbl[i].n < half) ? tbl[i].n : half);
            repeat (3) @(posedge clk);
            #1;
        end

        // pix_valid held through FLUSH: 7 waits one cycle, nothing lost or duplicated.
        lp = '{default: 8'd0};
        lp[0] = 8'd10; lp[1] = 8'd20;
        push_line(0, lp, 2, 2, 1'b1);
        lp[0] = 8'd7; lp[1] = 8'd8; lp[2] = 8'd9;
        push_line(0, lp, 3, 3, 1'b1);
        send(0, 8'd10, 1'b1, 1'b0, w);
        send(0, 8'd20, 1'b0, 1'b1, w);
        send(0, 8'd7,  1'b1, 1'b0, w);
        chk("hold_wait", w, 1);
        send(0, 8'd8,  1'b0, 1'b0, w);
        chk("hold_next", w, 0);
        send(0, 8'd9,  1'b0, 1'b1, w);
        idle(0);
        bubble(0, b);
        repeat (3) @(posedge clk);
        #1;

        // Mid-line line_start aborts the open line.
        lp = '{default: 8'd0};
        lp[0] = 8'd10; lp[1] = 8'd20; lp[2] = 8'd30;
        push_line(0, lp, 3, 2, 1'b0);
        lp[0] = 8'd50; lp[1] = 8'd60;
        push_line(0, lp, 2, 2, 1'b1);
        send(0, 8'd10, 1'b1, 1'b0, w);
        send(0, 8'd20, 1'b0, 1'b0, w);
        send(0, 8'd30, 1'b0, 1'b0, w);
        send(0, 8'd50, 1'b1, 1'b0, w);
        send(0, 8'd60, 1'b0, 1'b1, w);
        idle(0);
        bubble(0, b);
        chk("abort_bubble", b, 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in mid-line: outputs clear immediately, stray pixels ignored afterwards.
        lp = '{default: 8'd0};
        lp[0] = 8'd11; lp[1] = 8'd22;
        push_line(0, lp, 2, 1, 1'b0);
        send(0, 8'd11, 1'b1, 1'b0, w);
        send(0, 8'd22, 1'b0, 1'b0, w);
        idle(0);
        @(negedge clk);
        #1;
        chk("pre_reset_valid", if3.win_valid, 1);
        rst_n = 1'b0;
        #1;
        reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'd33, 1'b0, 1'b0, w);
        chk("post_reset_ready", w, 0);
        send(0, 8'd44, 1'b0, 1'b1, w);
        idle(0);
        bubble(0, b);
        chk("dropped_no_flush", b, 0);
        lp = '{default: 8'd0};
        lp[0] = 8'd1; lp[1] = 8'd2; lp[2] = 8'd3;
        push_line(0, lp, 3, 3, 1'b1);
        send(0, 8'd1, 1'b1, 1'b0, w);
        send(0, 8'd2, 1'b0, 1'b0, w);
        send(0, 8'd3, 1'b0, 1'b1, w);
        idle(0);
        bubble(0, b);
        repeat (5) @(posedge clk);
        #1;

        chk("queue3_drained", q3.size(), 0);
        chk("queue5_drained", q5.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
